// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS M-stage port: word SRAM with byte/half lane
// merging, programmable wait states, pipeline stall and address-error flag.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall,
  output logic        addr_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic [31:0] mem [DEPTH];

  logic        access;
  logic        a_we;
  logic [31:0] a_addr, a_wdata;
  logic [1:0]  a_size;
  logic        misaligned, out_of_range, err;
  logic [3:0]  be;
  logic [31:0] wrep;
  logic [AW-1:0] widx;

  // The request cycle counts as the first stalled cycle, so the counter is
  // preloaded one short; with no wait states the access completes straight from
  // IDLE using the live inputs, giving DONE (ready) at T+1+WAIT_CYCLES.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    access     = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          if (WAIT_CYCLES == 0) begin
            state_next = DONE;
            access     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          state_next = DONE;
          access     = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    if (state == IDLE) begin
      a_we    = we;
      a_addr  = addr;
      a_wdata = wdata;
      a_size  = size;
    end else begin
      a_we    = we_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
      a_size  = size_q;
    end
  end

  always_comb begin
    misaligned = 1'b0;
    be         = 4'b1111;
    wrep       = a_wdata;
    case (a_size)
      2'b00: begin
        be   = 4'b0001 << a_addr[1:0];
        wrep = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = a_addr[0];
        be         = 4'b0011 << a_addr[1:0];
        wrep       = {2{a_wdata[15:0]}};
      end
      default: misaligned = (a_addr[1:0] != 2'b00);
    endcase
    out_of_range = |a_addr[31:AW+2];
    err          = misaligned | out_of_range;
    widx         = a_addr[AW+1:2];
  end

  assign stall = en & (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rdata    <= '0;
      ready    <= 1'b0;
      addr_err <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      ready    <= access;
      addr_err <= access & err;
      if (state == IDLE && en) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        size_q  <= size;
      end
      if (access) begin
        if (err)        rdata <= '0;
        else if (!a_we) rdata <= mem[widx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && access && a_we && !err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

endmodule
